// File: rtl/img_reg_pkg.sv
// img_reg_pkg: shared constants, state encoding and counter widths for the
// image-register read sequencer.
package img_reg_pkg;
   localparam logic [7:0]  ADDR_IMG_SIZE = 8'h01;
   localparam logic [7:0]  ADDR_NUM_IMG  = 8'h02;
   localparam logic [7:0]  ADDR_STATUS   = 8'h03;
   localparam logic [31:0] ERR_WORD      = 32'hFFFF_FFFF;
   localparam int          CMD_CNT_W     = 16;
   localparam int          TO_CNT_W      = 8;
   localparam int          ERR_CNT_W     = 8;
   typedef enum logic [1:0] {IDLE, REQ, WAIT, SHIFT} state_t;
endpackage

// File: rtl/img_reg_read_sequencer_byte_serializer.sv
// byte_serializer: loads a 32-bit word and emits it MSB-first as four bytes
// over a ready/valid handshake; o_done marks the fourth accepted byte.
module byte_serializer (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_load,
   input  logic [31:0] i_word,
   input  logic        i_ready,
   output logic [7:0]  o_byte,
   output logic        o_valid,
   output logic        o_done
);
   logic [31:0] r_word;
   logic [1:0]  r_cnt;
   logic        r_valid;
   logic        w_hs;

   assign w_hs    = r_valid && i_ready;
   assign o_byte  = r_word[31:24];
   assign o_valid = r_valid;
   assign o_done  = w_hs && (r_cnt == 2'd3);

   // Shifting zeros in leaves the byte output at 0 once the word is drained.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_word  <= '0;
         r_cnt   <= '0;
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_word  <= i_word;
         r_cnt   <= '0;
         r_valid <= 1'b1;
      end else if (w_hs) begin
         r_word  <= {r_word[23:0], 8'h00};
         r_cnt   <= r_cnt + 2'd1;
         r_valid <= (r_cnt != 2'd3);
      end
   end
endmodule

// File: rtl/img_reg_read_sequencer.sv
// img_reg_read_sequencer: decodes register-read commands, strobes the selected
// source, and streams the 32-bit result as bytes. Optional wait timeout: REG_TIMEOUT_EN.
module img_reg_read_sequencer
   import img_reg_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic        sysClk,
   input  logic        sysRst_n,
   input  logic [7:0]  cmd_addr,
   input  logic [16:0] cmd_data,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   output logic        read_img_size,
   output logic [15:0] img_index,
   input  logic [31:0] jpg_size,
   input  logic        jpg_size_valid,
   output logic        read_num_img,
   input  logic [31:0] num_both_img,
   input  logic        num_both_img_valid,
   output logic [7:0]  byte_out,
   output logic        byte_out_valid,
   input  logic        byte_out_ready,
   output logic        busy,
   output logic        err_pulse,
   output logic        timeout_pulse
);
   state_t               r_state;
   logic [7:0]           r_addr;
   logic [15:0]          r_img_index;
   logic [CMD_CNT_W-1:0] r_cmd_count;
   logic [TO_CNT_W-1:0]  r_to_count;
   logic [ERR_CNT_W-1:0] r_err_count;
   logic                 r_cmd_ready, r_read_img, r_read_num, r_err_pulse, r_to_pulse;
   logic                 w_accept, w_known, w_sel_img, w_src_valid, w_capture, w_expire;
   logic                 w_load, w_done;
   logic [31:0]          w_src_word, w_word;

   assign w_accept    = (r_state == IDLE) && r_cmd_ready && cmd_valid;
   assign w_known     = (cmd_addr == ADDR_IMG_SIZE) || (cmd_addr == ADDR_NUM_IMG);
   assign w_sel_img   = (r_addr == ADDR_IMG_SIZE);
   assign w_src_valid = w_sel_img ? jpg_size_valid : num_both_img_valid;
   assign w_src_word  = w_sel_img ? jpg_size : num_both_img;
   assign w_capture   = (r_state == WAIT) && w_src_valid;

`ifdef REG_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
   logic [TW-1:0] r_wait_cnt;
   // A valid on the expiry cycle takes priority over the timeout.
   assign w_expire = (r_state == WAIT) && !w_src_valid && (r_wait_cnt == TW'(TIMEOUT_CYCLES - 1));
   always_ff @(posedge sysClk or negedge sysRst_n) begin
      if (!sysRst_n) r_wait_cnt <= '0;
      else           r_wait_cnt <= (r_state == WAIT) ? r_wait_cnt + 1'b1 : '0;
   end
`else
   assign w_expire = 1'b0;
`endif

   assign w_load = (w_accept && !w_known) || w_capture || w_expire;
   assign w_word = w_capture ? w_src_word :
                   (w_accept && cmd_addr == ADDR_STATUS) ? {r_cmd_count, r_to_count, r_err_count} :
                   ERR_WORD;

   byte_serializer u_ser (
      .clk     (sysClk),
      .rst_n   (sysRst_n),
      .i_load  (w_load),
      .i_word  (w_word),
      .i_ready (byte_out_ready),
      .o_byte  (byte_out),
      .o_valid (byte_out_valid),
      .o_done  (w_done)
   );

   always_ff @(posedge sysClk or negedge sysRst_n) begin
      if (!sysRst_n) begin
         r_state     <= IDLE;
         r_addr      <= '0;
         r_img_index <= '0;
         r_cmd_count <= '0;
         r_to_count  <= '0;
         r_err_count <= '0;
         r_cmd_ready <= 1'b0;
         r_read_img  <= 1'b0;
         r_read_num  <= 1'b0;
         r_err_pulse <= 1'b0;
         r_to_pulse  <= 1'b0;
      end else begin
         r_read_img  <= 1'b0;
         r_read_num  <= 1'b0;
         r_err_pulse <= 1'b0;
         r_to_pulse  <= w_expire;
         if (w_expire) r_to_count <= r_to_count + TO_CNT_W'(~&r_to_count);
         case (r_state)
            IDLE: begin
               r_cmd_ready <= !w_accept;
               if (w_accept) begin
                  r_addr      <= cmd_addr;
                  r_cmd_count <= r_cmd_count + CMD_CNT_W'(~&r_cmd_count);
                  r_read_img  <= (cmd_addr == ADDR_IMG_SIZE);
                  r_read_num  <= (cmd_addr == ADDR_NUM_IMG);
                  if (cmd_addr == ADDR_IMG_SIZE) r_img_index <= cmd_data[15:0];
                  r_state <= w_known ? REQ : SHIFT;
                  if (!w_known && cmd_addr != ADDR_STATUS) begin
                     r_err_pulse <= 1'b1;
                     r_err_count <= r_err_count + ERR_CNT_W'(~&r_err_count);
                  end
               end
            end
            REQ:   r_state <= WAIT;
            WAIT:  if (w_capture || w_expire) r_state <= SHIFT;
            SHIFT: if (w_done) begin
               r_state     <= IDLE;
               r_cmd_ready <= 1'b1;
            end
         endcase
      end
   end

   assign cmd_ready     = r_cmd_ready;
   assign read_img_size = r_read_img;
   assign read_num_img  = r_read_num;
   assign img_index     = r_img_index;
   assign busy          = (r_state != IDLE);
   assign err_pulse     = r_err_pulse;
   assign timeout_pulse = r_to_pulse;
endmodule

// File: tb/tb_img_reg_read_sequencer.sv
// tb_img_reg_read_sequencer: directed checks of the read sequencer; honours
// REG_TIMEOUT_EN with TIMEOUT_CYCLES=8.
module tb_img_reg_read_sequencer;
   logic        sysClk = 1'b0;
   logic        sysRst_n = 1'b1;
   logic [7:0]  cmd_addr = '0;
   logic [16:0] cmd_data = '0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready, read_img_size, read_num_img, byte_out_valid, busy, err_pulse, timeout_pulse;
   logic [15:0] img_index;
   logic [31:0] jpg_size = '0, num_both_img = '0;
   logic        jpg_size_valid = 1'b0, num_both_img_valid = 1'b0, byte_out_ready = 1'b1;
   logic [7:0]  byte_out;
   int          n_checks = 0, n_fail = 0, n_img = 0, n_num = 0, n_both = 0;
   logic [31:0] exp_status;

   img_reg_read_sequencer #(.TIMEOUT_CYCLES(8)) dut (
      .sysClk(sysClk), .sysRst_n(sysRst_n), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .read_img_size(read_img_size),
      .img_index(img_index), .jpg_size(jpg_size), .jpg_size_valid(jpg_size_valid),
      .read_num_img(read_num_img), .num_both_img(num_both_img),
      .num_both_img_valid(num_both_img_valid), .byte_out(byte_out),
      .byte_out_valid(byte_out_valid), .byte_out_ready(byte_out_ready), .busy(busy),
      .err_pulse(err_pulse), .timeout_pulse(timeout_pulse)
   );

   always #5 sysClk = ~sysClk;

   always @(posedge sysClk) begin
      if (read_img_size) n_img++;
      if (read_num_img) n_num++;
      if (read_img_size && read_num_img) n_both++;
   end

   task automatic tick;
      @(posedge sysClk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, " cmd_ready"}, 32'(cmd_ready), 0);
      chk({tag, " busy"}, 32'(busy), 0);
      chk({tag, " bvalid"}, 32'(byte_out_valid), 0);
      chk({tag, " byte"}, 32'(byte_out), 0);
      chk({tag, " strobes"}, 32'({read_img_size, read_num_img}), 0);
      chk({tag, " pulses"}, 32'({err_pulse, timeout_pulse}), 0);
      chk({tag, " index"}, 32'(img_index), 0);
   endtask

   task automatic do_reset;
      sysRst_n = 1'b0;
      #1;
      chk_idle_outputs("rst");
      tick;
      tick;
      chk("rst held ready", 32'(cmd_ready), 0);
      sysRst_n = 1'b1;
      tick;
      chk("rst release ready", 32'(cmd_ready), 1);
   endtask

   task automatic send(input logic [7:0] a, input logic [15:0] d);
      cmd_addr  = a;
      cmd_data  = {1'b1, d};
      cmd_valid = 1'b1;
      chk("pre-accept ready", 32'(cmd_ready), 1);
      tick;
      cmd_valid = 1'b0;
   endtask

   task automatic recv(input logic [31:0] w, input bit tog, input string tag);
      for (int i = 0; i < 4; i++) begin
         int t = 0;
         if (tog) byte_out_ready = 1'b0;
         while (!byte_out_valid && t < 40) begin
            tick;
            t++;
         end
         chk({tag, " valid"}, 32'(byte_out_valid), 1);
         if (!tog && i > 0) chk({tag, " gap"}, 32'(t), 0);
         if (tog) begin
            tick;
            chk({tag, " held valid"}, 32'(byte_out_valid), 1);
         end
         chk({tag, " byte"}, 32'(byte_out), 32'(w[31-8*i -: 8]));
         byte_out_ready = 1'b1;
         tick;
      end
      chk({tag, " ready after"}, 32'(cmd_ready), 1);
      chk({tag, " busy after"}, 32'(busy), 0);
   endtask

   initial begin
      #3;
      do_reset;

      // JPEG size read, valid one cycle later than earliest
      jpg_size = 32'h1234_5678;
      send(8'h01, 16'h0005);
      chk("img strobe", 32'({read_img_size, read_num_img}), 32'b10);
      chk("img index", 32'(img_index), 5);
      chk("img busy", 32'({busy, cmd_ready}), 32'b10);
      tick;
      chk("img strobe off", 32'(read_img_size), 0);
      tick;
      chk("img no early byte", 32'(byte_out_valid), 0);
      jpg_size_valid = 1'b1;
      tick;
      jpg_size_valid = 1'b0;
      recv(32'h1234_5678, 1'b0, "img");
      chk("img strobe count", 32'(n_img), 1);

      // image count read with back-pressure
      num_both_img = 32'h0000_0003;
      send(8'h02, 16'h0009);
      chk("num strobe", 32'({read_img_size, read_num_img}), 32'b01);
      chk("num index held", 32'(img_index), 5);
      tick;
      num_both_img_valid = 1'b1;
      tick;
      num_both_img_valid = 1'b0;
      recv(32'h0000_0003, 1'b1, "num");
      chk("num strobe counts", 32'({n_img[15:0], n_num[15:0]}), 32'h0001_0001);

      // unknown address then status
      do_reset;
      send(8'h7F, 16'h0000);
      chk("err pulse", 32'(err_pulse), 1);
      chk("err first byte", 32'(byte_out_valid), 1);
      recv(32'hFFFF_FFFF, 1'b0, "err");
      send(8'h03, 16'h0000);
      chk("stat no err", 32'(err_pulse), 0);
      recv(32'h0001_0001, 1'b0, "stat");

      // wait without a valid
      send(8'h01, 16'h0009);
      tick;
`ifdef REG_TIMEOUT_EN
      begin
         int t = 0;
         while (!timeout_pulse && t < 40) begin
            tick;
            t++;
         end
      end
      chk("timeout pulse", 32'(timeout_pulse), 1);
      recv(32'hFFFF_FFFF, 1'b0, "tmo");
      exp_status = 32'h0003_0101;
`else
      repeat (40) tick;
      chk("wait held busy", 32'(busy), 1);
      chk("wait no byte", 32'({byte_out_valid, timeout_pulse}), 0);
      jpg_size = 32'hCAFE_F00D;
      jpg_size_valid = 1'b1;
      tick;
      jpg_size_valid = 1'b0;
      recv(32'hCAFE_F00D, 1'b0, "slow");
      exp_status = 32'h0003_0001;
`endif
      send(8'h03, 16'h0000);
      recv(exp_status, 1'b0, "stat2");

      // stray valids in IDLE, REQ and from the other source
      jpg_size = 32'h0000_DEAD;
      jpg_size_valid = 1'b1;
      tick;
      jpg_size_valid = 1'b0;
      chk("idle valid ignored", 32'({busy, byte_out_valid, cmd_ready}), 32'b001);
      jpg_size = 32'hA1B2_C3D4;
      send(8'h01, 16'h0007);
      jpg_size_valid = 1'b1;
      tick;
      jpg_size_valid = 1'b0;
      chk("req valid ignored", 32'(byte_out_valid), 0);
      num_both_img = 32'h0000_0055;
      num_both_img_valid = 1'b1;
      tick;
      num_both_img_valid = 1'b0;
      chk("other valid ignored", 32'({busy, byte_out_valid}), 32'b10);
      jpg_size_valid = 1'b1;
      tick;
      jpg_size_valid = 1'b0;
      recv(32'hA1B2_C3D4, 1'b0, "late");

      // reset after the second byte
      num_both_img = 32'h1122_3344;
      send(8'h02, 16'h0000);
      tick;
      num_both_img_valid = 1'b1;
      tick;
      num_both_img_valid = 1'b0;
      tick;
      tick;
      chk("mid third byte", 32'(byte_out), 32'h33);
      sysRst_n = 1'b0;
      #1;
      chk_idle_outputs("mid rst");
      tick;
      sysRst_n = 1'b1;
      chk("mid rst ready low", 32'(cmd_ready), 0);
      tick;
      chk("mid rst ready", 32'(cmd_ready), 1);
      chk("mid rst no byte", 32'(byte_out_valid), 0);
      send(8'h03, 16'h0000);
      recv(32'h0000_0000, 1'b0, "post stat");
      jpg_size = 32'h0BAD_BEEF;
      send(8'h01, 16'h0002);
      tick;
      jpg_size_valid = 1'b1;
      tick;
      jpg_size_valid = 1'b0;
      recv(32'h0BAD_BEEF, 1'b0, "post img");
      chk("post index", 32'(img_index), 2);

      chk("final strobes", 32'({n_img[15:0], n_num[15:0]}), 32'h0004_0002);
      chk("never both strobes", 32'(n_both), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
